// File: rtl/daq_buf_alloc.sv
// Space allocator and write sequencer for the DAQ best/raw rings: grants or drops each L1A,
// pulses l1a_grant/l1a_drop one cycle after l1a_req, runs the write window from the grant cycle.

module daq_buf_fifo #(
    parameter int W   = 9,
    parameter int AWF = 4
) (
    input  logic         clk,
    input  logic         hard_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat
);
    logic [W-1:0]   mem [2**AWF];
    logic [AWF-1:0] wr_ptr;
    logic [AWF-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!hard_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

    assign rdat = mem[rd_ptr];
endmodule

module daq_buf_alloc #(
    parameter int AW  = 8,
    parameter int EVW = 4
) (
    input  logic          clk,
    input  logic          hard_rst,
    input  logic          l1a_req,
    input  logic [3:0]    lct_bins,
    input  logic [4:0]    raw_bins,
    input  logic          raw_en,
    input  logic          rd_done,
    output logic          l1a_grant,
    output logic          l1a_drop,
    output logic [AW-1:0] best_base,
    output logic [AW-1:0] raw_base,
    output logic [11:0]   ev_count,
    output logic          best_we,
    output logic [AW-1:0] best_adw,
    output logic          raw_we,
    output logic [AW-1:0] raw_adw,
    output logic          best_full,
    output logic          raw_full,
    output logic [EVW:0]  outstanding,
    output logic          alloc_err
);
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [AW:0] MAXW = {1'b0, {AW{1'b1}}};

    state_t      state;
    logic [AW:0] best_used;
    logic [AW:0] raw_used;
    logic [3:0]  best_rem;
    logic [4:0]  raw_rem;
    logic [8:0]  head;

    logic [4:0]   rb;
    logic         rel;
    logic [AW:0]  lb_ext, rb_ext;
    logic [AW:0]  best_post, raw_post;
    logic [EVW:0] out_post;
    logic         best_ok, raw_ok, ev_ok, grant_ok;
    logic         best_we_nxt, raw_we_nxt;

    assign rb     = raw_en ? raw_bins : 5'd0;
    assign rel    = rd_done && (outstanding != '0);
    assign lb_ext = {{(AW-3){1'b0}}, lct_bins};
    assign rb_ext = {{(AW-4){1'b0}}, rb};

    // Occupancy after any same-cycle release; the space check must see this, not the raw counters.
    assign best_post = best_used - (rel ? {{(AW-3){1'b0}}, head[8:5]} : '0);
    assign raw_post  = raw_used  - (rel ? {{(AW-4){1'b0}}, head[4:0]} : '0);
    assign out_post  = outstanding - {{EVW{1'b0}}, rel};

    assign best_ok  = (best_post + lb_ext) <= MAXW;
    assign raw_ok   = (raw_post + rb_ext) <= MAXW;
    assign ev_ok    = !out_post[EVW];
    assign grant_ok = (state == IDLE) && l1a_req && best_ok && raw_ok && ev_ok;

    assign best_we_nxt = best_we && (best_rem > 4'd1);
    assign raw_we_nxt  = raw_we && (raw_rem > 5'd1);

    daq_buf_fifo #(.W(9), .AWF(EVW)) u_size_fifo (
        .clk      (clk),
        .hard_rst (hard_rst),
        .push     (grant_ok),
        .pop      (rel),
        .wdat     ({lct_bins, rb}),
        .rdat     (head)
    );

    always_ff @(posedge clk) begin
        if (!hard_rst) begin
            state       <= IDLE;
            best_used   <= '0;
            raw_used    <= '0;
            outstanding <= '0;
            ev_count    <= '0;
            best_adw    <= {{(AW-1){1'b0}}, 1'b1};
            raw_adw     <= {{(AW-1){1'b0}}, 1'b1};
            best_base   <= '0;
            raw_base    <= '0;
            best_rem    <= '0;
            raw_rem     <= '0;
            best_we     <= 1'b0;
            raw_we      <= 1'b0;
            l1a_grant   <= 1'b0;
            l1a_drop    <= 1'b0;
            alloc_err   <= 1'b0;
            best_full   <= 1'b0;
            raw_full    <= 1'b0;
        end else begin
            l1a_grant   <= grant_ok;
            l1a_drop    <= l1a_req && !grant_ok;
            alloc_err   <= rd_done && (outstanding == '0);
            best_full   <= !best_ok || !ev_ok;
            raw_full    <= !raw_ok || !ev_ok;
            best_used   <= best_post + (grant_ok ? lb_ext : '0);
            raw_used    <= raw_post + (grant_ok ? rb_ext : '0);
            outstanding <= out_post + {{EVW{1'b0}}, grant_ok};

            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        best_base <= best_adw;
                        raw_base  <= raw_adw;
                        ev_count  <= ev_count + 12'd1;
                        best_rem  <= lct_bins;
                        raw_rem   <= rb;
                        best_we   <= (lct_bins != 4'd0);
                        raw_we    <= (rb != 5'd0);
                        // Empty-record events are granted but never enter the write window.
                        state     <= ((lct_bins != 4'd0) || (rb != 5'd0)) ? WRITE : IDLE;
                    end
                end
                WRITE: begin
                    if (best_we) begin
                        best_adw <= best_adw + 1'b1;
                        best_rem <= best_rem - 4'd1;
                    end
                    if (raw_we) begin
                        raw_adw <= raw_adw + 1'b1;
                        raw_rem <= raw_rem - 5'd1;
                    end
                    best_we <= best_we_nxt;
                    raw_we  <= raw_we_nxt;
                    if (!best_we_nxt && !raw_we_nxt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_daq_buf_alloc.sv
// Scoreboard bench for daq_buf_alloc: expected grant/drop records are queued at request time.
module tb_daq_buf_alloc;
    logic        clk = 1'b0;
    logic        hard_rst = 1'b0;
    logic        l1a_req = 1'b0;
    logic [3:0]  lct_bins = '0;
    logic [4:0]  raw_bins = '0;
    logic        raw_en = 1'b0;
    logic        rd_done = 1'b0;
    logic        l1a_grant, l1a_drop;
    logic [7:0]  best_base, raw_base;
    logic [11:0] ev_count;
    logic        best_we, raw_we;
    logic [7:0]  best_adw, raw_adw;
    logic        best_full, raw_full;
    logic [4:0]  outstanding;
    logic        alloc_err;

    daq_buf_alloc #(.AW(8), .EVW(4)) dut (
        .clk(clk), .hard_rst(hard_rst), .l1a_req(l1a_req), .lct_bins(lct_bins),
        .raw_bins(raw_bins), .raw_en(raw_en), .rd_done(rd_done),
        .l1a_grant(l1a_grant), .l1a_drop(l1a_drop), .best_base(best_base),
        .raw_base(raw_base), .ev_count(ev_count), .best_we(best_we), .best_adw(best_adw),
        .raw_we(raw_we), .raw_adw(raw_adw), .best_full(best_full), .raw_full(raw_full),
        .outstanding(outstanding), .alloc_err(alloc_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        g;
        logic [7:0]  bb;
        logic [7:0]  rb;
        logic [11:0] evc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_bwe = 0;
    int   cnt_rwe = 0;

    int         m_bu, m_ru, m_out, m_evc;
    logic [7:0] m_bp, m_rp;
    int         q_lb[$], q_rb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (best_we) cnt_bwe++;
        if (raw_we)  cnt_rwe++;
        if (l1a_grant || l1a_drop) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {30'd0, l1a_grant, l1a_drop}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp", {30'd0, l1a_grant, l1a_drop}, e.g ? 32'd2 : 32'd1);
                if (e.g) begin
                    chk("best_base", {24'd0, best_base}, {24'd0, e.bb});
                    chk("raw_base", {24'd0, raw_base}, {24'd0, e.rb});
                    chk("ev_count", {20'd0, ev_count}, {20'd0, e.evc});
                end
            end
        end
    end

    function automatic logic exp_bfull(input int lb);
        return (m_bu + lb > 255) || (m_out >= 16);
    endfunction

    function automatic logic exp_rfull(input int rb);
        return (m_ru + rb > 255) || (m_out >= 16);
    endfunction

    task automatic model_release(input bit rd);
        if (rd && m_out > 0) begin
            m_bu -= q_lb.pop_front();
            m_ru -= q_rb.pop_front();
            m_out--;
        end
    endtask

    task automatic do_reset();
        hard_rst = 1'b0;
        l1a_req  = 1'b0;
        rd_done  = 1'b0;
        @(posedge clk); #1;
        hard_rst = 1'b1;
        m_bu = 0; m_ru = 0; m_out = 0; m_evc = 0; m_bp = 8'd1; m_rp = 8'd1;
        q_lb.delete(); q_rb.delete();
        cnt_bwe = 0; cnt_rwe = 0;
        chk("sb_empty_at_reset", sb.size(), 0);
    endtask

    // busy: request lands inside a write window; wt: sit out the window after a grant
    task automatic req(input int lb, input int rbin, input bit en, input bit rd,
                       input bit busy, input bit wt);
        int   rb;
        bit   ok;
        exp_t e;
        int   n;
        rb = en ? rbin : 0;
        model_release(rd);
        ok = !busy && (m_bu + lb <= 255) && (m_ru + rb <= 255) && (m_out < 16);
        e.g   = ok;
        e.bb  = m_bp;
        e.rb  = m_rp;
        e.evc = 12'((m_evc + 1) % 4096);
        sb.push_back(e);
        n = 0;
        if (ok) begin
            m_evc = (m_evc + 1) % 4096;
            m_bp  = m_bp + 8'(lb);
            m_rp  = m_rp + 8'(rb);
            m_bu += lb; m_ru += rb; m_out++;
            q_lb.push_back(lb); q_rb.push_back(rb);
            n = (lb > rb) ? lb : rb;
        end
        l1a_req = 1'b1; lct_bins = 4'(lb); raw_bins = 5'(rbin); raw_en = en; rd_done = rd;
        @(posedge clk); #1;
        l1a_req = 1'b0; rd_done = 1'b0;
        if (wt && n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic rel_pulse(output bit aerr);
        aerr = (m_out == 0);
        model_release(1'b1);
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
    endtask

    initial begin
        bit aerr;

        // reset state
        do_reset();
        chk("rst_best_adw", {24'd0, best_adw}, 32'd1);
        chk("rst_raw_adw", {24'd0, raw_adw}, 32'd1);
        chk("rst_outstanding", {27'd0, outstanding}, 32'd0);
        chk("rst_ev_count", {20'd0, ev_count}, 32'd0);
        chk("rst_we", {30'd0, best_we, raw_we}, 32'd0);

        // basic 7/8 window
        req(7, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_bwe_cycles", cnt_bwe, 7);
        chk("t1_rwe_cycles", cnt_rwe, 8);
        chk("t1_best_adw", {24'd0, best_adw}, 32'd8);
        chk("t1_raw_adw", {24'd0, raw_adw}, 32'd9);
        chk("t1_outstanding", {27'd0, outstanding}, m_out);

        // empty-record events stay in IDLE, so a back-to-back request is granted
        do_reset();
        req(0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        req(0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t2_no_we", cnt_bwe + cnt_rwe, 0);
        chk("t2_outstanding", {27'd0, outstanding}, m_out);
        chk("t2_ev_count", {20'd0, ev_count}, m_evc);
        chk("t2_best_adw", {24'd0, best_adw}, 32'd1);

        // event-count limit
        do_reset();
        for (int i = 0; i < 16; i++) req(1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        req(1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_best_full", {31'd0, best_full}, {31'd0, exp_bfull(1)});
        chk("t3_outstanding16", {27'd0, outstanding}, m_out);
        rel_pulse(aerr);
        chk("t3_outstanding15", {27'd0, outstanding}, m_out);
        chk("t3_best_full_clr", {31'd0, best_full}, {31'd0, exp_bfull(1)});
        req(1, 0, 1'b1, 1'b0, 1'b0, 1'b1);

        // raw ring fills after 15 x 16 words
        do_reset();
        for (int i = 0; i < 16; i++) req(15, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_raw_full", {31'd0, raw_full}, {31'd0, exp_rfull(16)});
        chk("t4_raw_adw", {24'd0, raw_adw}, {24'd0, m_rp});

        // same-cycle release and request: granted, raw pointer wraps past 255
        req(15, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_raw_adw_wrap", {24'd0, raw_adw}, {24'd0, m_rp});
        chk("t5_best_adw", {24'd0, best_adw}, {24'd0, m_bp});
        chk("t5_outstanding", {27'd0, outstanding}, m_out);
        req(15, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_raw_full", {31'd0, raw_full}, {31'd0, exp_rfull(16)});

        // release with nothing outstanding
        do_reset();
        rel_pulse(aerr);
        chk("t6_alloc_err", {31'd0, alloc_err}, {31'd0, aerr});
        chk("t6_outstanding", {27'd0, outstanding}, 32'd0);
        @(posedge clk); #1;
        chk("t6_alloc_err_pulse", {31'd0, alloc_err}, 32'd0);

        // request in the grant cycle of a write window
        do_reset();
        req(7, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        req(3, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("t7_bwe_cycles", cnt_bwe, 7);
        chk("t7_rwe_cycles", cnt_rwe, 8);
        chk("t7_raw_adw", {24'd0, raw_adw}, {24'd0, m_rp});

        // reset aborts a window
        do_reset();
        req(15, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        hard_rst = 1'b0;
        @(posedge clk); #1;
        chk("t8_we_low", {30'd0, best_we, raw_we}, 32'd0);
        chk("t8_best_adw", {24'd0, best_adw}, 32'd1);
        chk("t8_raw_adw", {24'd0, raw_adw}, 32'd1);
        chk("t8_outstanding", {27'd0, outstanding}, 32'd0);
        chk("t8_ev_count", {20'd0, ev_count}, 32'd0);
        chk("t8_bases", {16'd0, best_base, raw_base}, 32'd0);
        hard_rst = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
